// File: rtl/iob_target.sv
// iob_target: PDS-side responder for 68000 cycles on the IOB bus.
//
// Decodes a four-register window at A[23:16] == BASE, synchronizes the
// asynchronous bus strobes into C16M, inserts WAITS wait states and then
// pulls /DTACK (open-drain enable) with read data driven on the same edge.
//
// Ports
//   C16M      clock, rising edge
//   nRES      asynchronous active-low reset
//   A_HI      IOB A[23:16], window decode
//   A_LO      IOB A[2:1], register index (0 CTRL, 1 STAT, 2 SCRATCH, 3 ID)
//   nAS       address strobe (async)
//   nUDS      upper data strobe (async)
//   nLDS      lower data strobe (async)
//   nWE       R/W, low = write (async)
//   Din       write data
//   Dout      read data, held through HOLD
//   DoutOE    1 = drive Dout onto the bus
//   nDTACKoe  1 = pull /DTACK low
//   CTRL      control register to QoS/accelerator logic
//   STATin    live status, sampled at ACK
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a synchronized /AS falling edge inside the window
// STROBE | address accepted, waiting for /UDS or /LDS
// WAIT   | counting wait states down to the acknowledge
// ACK    | one cycle: perform write / capture read data, assert /DTACK
// HOLD   | /DTACK and data held until synchronized /AS goes high

module iob_target #(
    parameter logic [7:0]  BASE     = 8'hFC,
    parameter int          WAITS    = 2,
    parameter logic [15:0] CTRL_RST = 16'h0000,
    parameter logic [15:0] ID_VAL   = 16'h5753
) (
    input  logic        C16M,
    input  logic        nRES,
    input  logic [7:0]  A_HI,
    input  logic [1:0]  A_LO,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        nWE,
    input  logic [15:0] Din,
    output logic [15:0] Dout,
    output logic        DoutOE,
    output logic        nDTACKoe,
    output logic [15:0] CTRL,
    input  logic [15:0] STATin
);

    generate
        if (WAITS < 0 || WAITS > 7) begin : g_waits_range
            $error("iob_target: WAITS must be 0..7");
        end
    endgenerate

    localparam logic [2:0] WAITS_C = 3'(WAITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic        r_as_m, r_as_s, r_as_prev;
    logic        r_uds_m, r_uds_s;
    logic        r_lds_m, r_lds_s;
    logic        r_we_m, r_we_s;
    logic [1:0]  r_idx;
    logic        r_wr;
    logic [2:0]  r_cnt;
    logic [15:0] r_ctrl;
    logic [15:0] r_scratch;
    logic [15:0] r_dout;
    logic        r_dout_oe;
    logic        r_dtack;

    logic        w_hit;
    logic        w_as_fall;
    logic        w_ds;
    logic [15:0] w_rd_data;

    assign w_hit     = (A_HI == BASE);
    assign w_as_fall = r_as_prev & ~r_as_s;
    assign w_ds      = ~r_uds_s | ~r_lds_s;

    always_comb begin
        w_rd_data = 16'h0000;
        case (r_idx)
            2'd0:    w_rd_data = r_ctrl;
            2'd1:    w_rd_data = STATin;
            2'd2:    w_rd_data = r_scratch;
            default: w_rd_data = ID_VAL;
        endcase
    end

    // Two-flop synchronizers; idle level of every strobe is high.
    always_ff @(posedge C16M or negedge nRES) begin
        if (!nRES) begin
            r_as_m    <= 1'b1;
            r_as_s    <= 1'b1;
            r_as_prev <= 1'b1;
            r_uds_m   <= 1'b1;
            r_uds_s   <= 1'b1;
            r_lds_m   <= 1'b1;
            r_lds_s   <= 1'b1;
            r_we_m    <= 1'b1;
            r_we_s    <= 1'b1;
        end else begin
            r_as_m    <= nAS;
            r_as_s    <= r_as_m;
            r_as_prev <= r_as_s;
            r_uds_m   <= nUDS;
            r_uds_s   <= r_uds_m;
            r_lds_m   <= nLDS;
            r_lds_s   <= r_lds_m;
            r_we_m    <= nWE;
            r_we_s    <= r_we_m;
        end
    end

    always_ff @(posedge C16M or negedge nRES) begin
        if (!nRES) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_wr      <= 1'b0;
            r_cnt     <= 3'd0;
            r_ctrl    <= CTRL_RST;
            r_scratch <= 16'h0000;
            r_dout    <= 16'h0000;
            r_dout_oe <= 1'b0;
            r_dtack   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A miss leaves the responder silent for the whole cycle.
                    if (w_as_fall && w_hit) begin
                        r_idx   <= A_LO;
                        r_wr    <= ~r_we_s;
                        r_cnt   <= WAITS_C;
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (r_as_s) begin
                        r_state <= S_IDLE;
                    end else if (w_ds) begin
                        r_state <= (r_cnt != 3'd0) ? S_WAIT : S_ACK;
                    end
                end
                S_WAIT: begin
                    // Abort wins over the terminal count.
                    if (r_as_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    // Strobes have been low for several edges, so Din is settled.
                    if (r_wr) begin
                        if (r_idx == 2'd0) begin
                            if (!r_uds_s) r_ctrl[15:8] <= Din[15:8];
                            if (!r_lds_s) r_ctrl[7:0]  <= Din[7:0];
                        end else if (r_idx == 2'd2) begin
                            if (!r_uds_s) r_scratch[15:8] <= Din[15:8];
                            if (!r_lds_s) r_scratch[7:0]  <= Din[7:0];
                        end
                    end else begin
                        r_dout    <= w_rd_data;
                        r_dout_oe <= 1'b1;
                    end
                    r_dtack <= 1'b1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_as_s) begin
                        r_dtack   <= 1'b0;
                        r_dout_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_dtack   <= 1'b0;
                    r_dout_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign Dout     = r_dout;
    assign DoutOE   = r_dout_oe;
    assign nDTACKoe = r_dtack;
    assign CTRL     = r_ctrl;

endmodule

// File: tb/tb_iob_target.sv
module tb_iob_target;

    localparam logic [7:0] BASE   = 8'hFC;
    localparam int         W_SLOW = 2;
    localparam int         W_FAST = 0;

    logic        C16M = 1'b0;
    logic        nRES = 1'b1;
    logic [7:0]  A_HI = 8'h00;
    logic [1:0]  A_LO = 2'd0;
    logic        nAS2 = 1'b1;
    logic        nAS0 = 1'b1;
    logic        nUDS = 1'b1;
    logic        nLDS = 1'b1;
    logic        nWE  = 1'b1;
    logic [15:0] Din  = 16'h0000;
    logic [15:0] STATin = 16'h0000;

    logic [15:0] Dout2, CTRL2, Dout0, CTRL0;
    logic        DoutOE2, dtack2, DoutOE0, dtack0;

    // cur selects which responder the tasks drive and observe: 0 = WAITS 2, 1 = WAITS 0
    logic        cur = 1'b0;
    logic        s_dtack, s_oe;
    logic [15:0] s_dout, s_ctrl;
    assign s_dtack = cur ? dtack0  : dtack2;
    assign s_oe    = cur ? DoutOE0 : DoutOE2;
    assign s_dout  = cur ? Dout0   : Dout2;
    assign s_ctrl  = cur ? CTRL0   : CTRL2;

    int n_chk = 0;
    int n_err = 0;
    int ack0_cnt = 0;
    logic [15:0] exp_q[$];

    iob_target #(.BASE(BASE), .WAITS(W_SLOW), .CTRL_RST(16'h0000), .ID_VAL(16'h5753)) dut (
        .C16M(C16M), .nRES(nRES), .A_HI(A_HI), .A_LO(A_LO), .nAS(nAS2),
        .nUDS(nUDS), .nLDS(nLDS), .nWE(nWE), .Din(Din), .Dout(Dout2),
        .DoutOE(DoutOE2), .nDTACKoe(dtack2), .CTRL(CTRL2), .STATin(STATin)
    );

    iob_target #(.BASE(BASE), .WAITS(W_FAST), .CTRL_RST(16'h0000), .ID_VAL(16'h5753)) dut0 (
        .C16M(C16M), .nRES(nRES), .A_HI(A_HI), .A_LO(A_LO), .nAS(nAS0),
        .nUDS(nUDS), .nLDS(nLDS), .nWE(nWE), .Din(Din), .Dout(Dout0),
        .DoutOE(DoutOE0), .nDTACKoe(dtack0), .CTRL(CTRL0), .STATin(STATin)
    );

    always #5 C16M = ~C16M;

    always @(posedge dtack0) ack0_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 2 sync edges + 1 edge to leave IDLE + 1 edge qualifying the strobe + WAITS + 1
    function automatic int ack_lat();
        return (cur ? W_FAST : W_SLOW) + 5;
    endfunction

    task automatic set_as(input logic v);
        if (cur) nAS0 = v;
        else     nAS2 = v;
    endtask

    task automatic start_cyc(input logic wr, input logic [1:0] idx, input logic [7:0] ahi,
                             input logic uds_n, input logic lds_n, input logic [15:0] din);
        @(negedge C16M);
        A_HI = ahi; A_LO = idx; nWE = ~wr; Din = din;
        set_as(1'b0); nUDS = uds_n; nLDS = lds_n;
    endtask

    task automatic end_cyc();
        @(negedge C16M);
        set_as(1'b1); nUDS = 1'b1; nLDS = 1'b1; nWE = 1'b1;
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge C16M); #1;
            if (s_dtack) begin lat = n; break; end
        end
    endtask

    task automatic wait_rel(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge C16M); #1;
            if (!s_dtack) begin lat = n; break; end
        end
    endtask

    task automatic finish_cyc(input string tag);
        int lat;
        end_cyc();
        wait_rel(lat);
        check_val({tag, "_rel"}, 32'(lat), 32'd3);
        check_val({tag, "_oe_off"}, 32'(s_oe), 32'd0);
    endtask

    task automatic read_ack(input logic [1:0] idx, input logic [15:0] exp, input string tag);
        int lat;
        exp_q.push_back(exp);
        start_cyc(1'b0, idx, BASE, 1'b0, 1'b0, 16'h0000);
        wait_ack(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(ack_lat()));
        check_val({tag, "_oe"}, 32'(s_oe), 32'd1);
        if (exp_q.size() > 0) check_val({tag, "_data"}, 32'(s_dout), 32'(exp_q.pop_front()));
        else check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    endtask

    task automatic do_read(input logic [1:0] idx, input logic [15:0] exp, input string tag,
                           input logic stat_chg);
        read_ack(idx, exp, tag);
        if (stat_chg) STATin = 16'h0000;
        repeat (3) @(posedge C16M);
        #1;
        check_val({tag, "_hold_data"}, 32'(s_dout), 32'(exp));
        check_val({tag, "_hold_oe"}, 32'(s_oe), 32'd1);
        finish_cyc(tag);
    endtask

    task automatic do_write(input logic [1:0] idx, input logic uds_n, input logic lds_n,
                            input logic [15:0] din, input string tag);
        int lat;
        start_cyc(1'b1, idx, BASE, uds_n, lds_n, din);
        wait_ack(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(ack_lat()));
        check_val({tag, "_oe"}, 32'(s_oe), 32'd0);
        finish_cyc(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rel, n0;
        logic seen;

        // power-on reset, checked before any clock edge
        #2 nRES = 1'b0;
        #1;
        check_val("por_dtack", 32'(dtack2), 32'd0);
        check_val("por_oe", 32'(DoutOE2), 32'd0);
        check_val("por_dout", 32'(Dout2), 32'd0);
        check_val("por_ctrl", 32'(CTRL2), 32'd0);
        repeat (3) @(posedge C16M);
        @(negedge C16M) nRES = 1'b1;
        repeat (2) @(posedge C16M);

        cur = 1'b0;
        do_write(2'd2, 1'b0, 1'b0, 16'hA55A, "wr_scr");
        do_read(2'd2, 16'hA55A, "rd_scr", 1'b0);

        do_write(2'd0, 1'b0, 1'b0, 16'h1234, "wr_ctrl");
        check_val("ctrl_word", 32'(s_ctrl), 32'h1234);
        do_write(2'd0, 1'b1, 1'b0, 16'hFFFF, "wr_ctrl_lo");
        check_val("ctrl_lo", 32'(s_ctrl), 32'h12FF);
        do_write(2'd0, 1'b0, 1'b1, 16'h0000, "wr_ctrl_hi");
        check_val("ctrl_hi", 32'(s_ctrl), 32'h00FF);
        do_read(2'd0, 16'h00FF, "rd_ctrl", 1'b0);

        do_read(2'd3, 16'h5753, "rd_id", 1'b0);
        do_write(2'd3, 1'b0, 1'b0, 16'h0000, "wr_id");
        do_read(2'd3, 16'h5753, "rd_id2", 1'b0);

        STATin = 16'h0F0F;
        do_read(2'd1, 16'h0F0F, "rd_stat", 1'b1);

        // miss: outside the window, nothing may be driven
        start_cyc(1'b0, 2'd3, 8'hFB, 1'b0, 1'b0, 16'h0000);
        seen = 1'b0;
        repeat (15) begin
            @(posedge C16M); #1;
            seen = seen | s_dtack | s_oe;
        end
        check_val("miss_quiet", 32'(seen), 32'd0);
        end_cyc();
        repeat (4) @(posedge C16M);

        // abort: /AS released so that its synchronized rise lands in WAIT
        start_cyc(1'b1, 2'd2, BASE, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge C16M);
        end_cyc();
        seen = 1'b0;
        repeat (15) begin
            @(posedge C16M); #1;
            seen = seen | s_dtack | s_oe;
        end
        check_val("abort_no_ack", 32'(seen), 32'd0);
        do_read(2'd2, 16'hA55A, "rd_after_abort", 1'b0);

        // WAITS=0, back-to-back reads with one cycle of /AS high between them
        cur = 1'b1;
        n0 = ack0_cnt;
        read_ack(2'd3, 16'h5753, "b2b_first");
        exp_q.push_back(16'h5753);
        @(negedge C16M);
        set_as(1'b1); nUDS = 1'b1; nLDS = 1'b1;
        @(negedge C16M);
        set_as(1'b0); nUDS = 1'b0; nLDS = 1'b0;
        rel = -1; lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge C16M); #1;
            if (!s_dtack && rel < 0) rel = n;
            if (s_dtack && rel > 0) begin lat = n; break; end
        end
        check_val("b2b_rel", 32'(rel), 32'd2);
        check_val("b2b_lat", 32'(lat), 32'(ack_lat()));
        if (exp_q.size() > 0) check_val("b2b_second_data", 32'(s_dout), 32'(exp_q.pop_front()));
        else check_val("b2b_sb_empty", 32'd1, 32'd0);
        finish_cyc("b2b_second");
        repeat (4) @(posedge C16M);
        check_val("b2b_ack_count", 32'(ack0_cnt - n0), 32'd2);

        // reset in HOLD must release the bus without waiting for a clock edge
        cur = 1'b0;
        read_ack(2'd0, 16'h00FF, "rst_rd");
        @(negedge C16M);
        #2 nRES = 1'b0;
        #1;
        check_val("rst_dtack", 32'(dtack2), 32'd0);
        check_val("rst_oe", 32'(DoutOE2), 32'd0);
        check_val("rst_ctrl", 32'(CTRL2), 32'd0);
        set_as(1'b1); nUDS = 1'b1; nLDS = 1'b1; nWE = 1'b1;
        repeat (2) @(posedge C16M);
        @(negedge C16M) nRES = 1'b1;
        repeat (2) @(posedge C16M);
        do_read(2'd2, 16'h0000, "rst_scr", 1'b0);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/iob_target.md
Name: iob_target

Overview:
- PDS-side bus responder: the card answers 68000 cycles issued by the Mac logic board on the IOB bus, the responder end of the IOB master protocol.
- Decodes a small register window (CTRL, STAT, SCRATCH, ID), synchronizes the asynchronous /AS, /UDS, /LDS and R/W strobes into C16M, and inserts programmable wait states.
- Drives /DTACK open-drain and controls the read-data output enable.
- CTRL bits feed the QoS/accelerator control logic; STAT reflects live status inputs.

Parameters:
- BASE, 8'hFC, match value for A[23:16].
- WAITS, 2, C16M cycles inserted between strobe qualification and /DTACK (0–7).
- CTRL_RST, 16'h0000, CTRL reset value.
- ID_VAL, 16'h5753, read-only ID register value.

Ports:
- C16M  in  1  sole clock, rising edge.
- nRES  in  1  asynchronous active-low reset.
- A_HI  in  8  IOB A[23:16].
- A_LO  in  2  IOB A[2:1], register index.
- nAS  in  1  IOB address strobe, asynchronous.
- nUDS  in  1  upper data strobe, asynchronous.
- nLDS  in  1  lower data strobe, asynchronous.
- nWE  in  1  IOB R/W (low = write), asynchronous.
- Din  in  16  IOB write data, valid while strobes are low.
- Dout  out  16  read data.
- DoutOE  out  1  1 = drive Dout onto IOB.
- nDTACKoe  out  1  1 = pull IOB /DTACK low; 0 = release.
- CTRL  out  16  control register.
- STATin  in  16  live status, sampled on read.

Behaviour:
- Reset is asynchronous, active while nRES=0. Reset values:
  - state=IDLE; sync flops = 1.
  - Dout=0, DoutOE=0, nDTACKoe=0.
  - CTRL=CTRL_RST, SCRATCH=0, wait counter=0.
- Synchronization:
  - nAS, nUDS, nLDS and nWE each pass through 2 flops: ASs, UDSs, LDSs, WEs.
  - Din is captured only in ACK entry, after the strobes have been low at least 3 edges, so it is stable without synchronizing.
- hit = (A_HI==BASE), sampled when leaving IDLE. A_HI/A_LO are stable while /AS is low.
- Register map by A_LO:
  - 0 CTRL, R/W.
  - 1 STAT, read-only, reads STATin.
  - 2 SCRATCH, R/W.
  - 3 ID, read-only, reads ID_VAL.
- States:
  - IDLE: ASs falling (prev 1, now 0) and hit → STROBE; latch index and WEs; counter ← WAITS. Miss → stay IDLE and never drive anything.
  - STROBE: wait for UDSs=0 or LDSs=0. Then → WAIT if counter≠0, else → ACK. ASs=1 → IDLE (abort, no side effect).
  - WAIT: counter decrements each cycle; at 1 → ACK. ASs=1 → IDLE (abort).
  - ACK (1 cycle):
    - Write: CTRL/SCRATCH byte lanes updated; UDSs=0 writes [15:8], LDSs=0 writes [7:0].
    - Read: Dout ← selected register.
    - Writes to STAT/ID are ignored but still acknowledged.
    - nDTACKoe←1; DoutOE←1 for reads. → HOLD.
  - HOLD: keep nDTACKoe and DoutOE. ASs=1 → nDTACKoe←0, DoutOE←0, → IDLE (same edge).
- Latency: from the first C16M edge at which UDSs/LDSs is low in STROBE to nDTACKoe=1 is WAITS+1 edges.
- Data and nDTACKoe assert on the same edge. Dout is held constant through HOLD.
- Back-to-back cycles: a new falling ASs is detected only after ASs returns to 1 in HOLD/IDLE, so there is no double acknowledge.
- Write with both strobes high at ACK is impossible: ACK is only reached from a qualified strobe.
- Reset mid-cycle (any state): immediate release of nDTACKoe/DoutOE; register contents revert to reset values.
- STAT is sampled once at ACK; later STATin changes do not alter Dout in HOLD.
- Counter is 3 bits; WAITS>7 is illegal (synthesis assertion).

Test Plan:
- Reset: nRES=0 mid-HOLD → nDTACKoe=0, DoutOE=0, CTRL=16'h0000 within the same cycle, not waiting for a clock edge.
- Word write then read, BASE hit:
  - Write SCRATCH=16'hA55A with both strobes → nDTACKoe=1 exactly 3 edges after strobe sync (WAITS=2).
  - Read back: Dout=16'hA55A, DoutOE=1 until nAS high.
- Byte lanes:
  - CTRL=16'h1234, then write Din=16'hFFFF with only nLDS low → CTRL=16'h12FF.
  - Then write with only nUDS low, Din=16'h0000 → CTRL=16'h00FF.
- Read-only registers:
  - Read ID → 16'h5753.
  - Write ID with 16'h0000, then read → still 16'h5753, write still acknowledged.
  - STATin=16'h0F0F at ACK, changed to 16'h0000 in HOLD → Dout stays 16'h0F0F.
- Miss and abort:
  - A_HI=8'hFB → nDTACKoe, DoutOE stay 0 for the whole cycle.
  - Hit write where nAS rises during WAIT → no ACK, SCRATCH unchanged, state IDLE.
- WAITS=0 and back-to-back:
  - Two consecutive reads separated by one C16M cycle of nAS high → exactly two acknowledges.
  - Each acknowledge asserted 1 edge after strobe sync; nDTACKoe deasserts on the first edge where the synchronized /AS is high.
